// File: rtl/eth_tx_framer.sv
// Store-and-forward Ethernet TX framer: packet FIFO with overflow/resync handling,
// then preamble/SFD, data, zero padding, CRC-32 and interpacket gap onto an MII/GMII PHY.
module eth_tx_framer #(
  parameter int PHY_W                  = 4,
  parameter int FIFO_AW                = 11,
  parameter int IFG_BYTES              = 12,
  parameter int MIN_FRAME              = 60,
  parameter int ALMOST_FULL_THRESHOLD  = 64,
  parameter int ALMOST_EMPTY_THRESHOLD = 64
) (
  input  logic             tx_clk,
  input  logic             rstn,
  input  logic [7:0]       tx_data,
  input  logic             tx_sop,
  input  logic             tx_eop,
  input  logic             tx_err,
  input  logic             tx_wren,
  output logic             tx_rdy,
  output logic             tx_a_full,
  output logic             tx_a_empty,
  output logic             tx_drop,
  output logic             eth_txen,
  output logic             eth_txer,
  output logic [PHY_W-1:0] eth_txd,
  output logic [15:0]      frames_sent
);
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int IFG_CYC = IFG_BYTES * 8 / PHY_W;
  localparam logic [15:0]      MIN16    = 16'(MIN_FRAME);
  // IDLE contributes one more quiet cycle before the next preamble word
  localparam logic [15:0]      IFG_LAST = 16'((IFG_CYC > 1) ? IFG_CYC - 1 : 1);
  localparam logic [FIFO_AW:0] ONE      = 1;

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, CRC, IFG} state_t;

  logic [10:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, pkt_start, pkt_cnt, count, base, store_addr;
  logic             in_pkt, dropping, rdy_en;
  logic             full, pkt_none, wr_acc, overflow, do_store, wr_eop, rd_adv, rd_eop;
  logic [10:0]      rd_word;

  state_t           state;
  logic [15:0]      cnt;
  logic             sub, last_sub, frame_err, err_now;
  logic [31:0]      crc, fcs;
  logic [7:0]       cur_byte;
  logic [PHY_W-1:0] word;
  logic             unused_sop;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign count      = wr_ptr - rd_ptr;
  assign full       = count[FIFO_AW];
  assign pkt_none   = (pkt_cnt == '0);
  // a full FIFO with no complete packet can only hold the open one, which will be dropped
  assign tx_rdy     = rdy_en & (~full | pkt_none);
  assign tx_a_full  = int'(count) > (DEPTH - ALMOST_FULL_THRESHOLD);
  assign tx_a_empty = int'(count) < ALMOST_EMPTY_THRESHOLD;
  assign wr_acc     = tx_wren & tx_rdy;
  assign overflow   = full & in_pkt & pkt_none;
  assign base       = in_pkt ? pkt_start : wr_ptr;
  assign do_store   = wr_acc & (tx_sop | (in_pkt & ~overflow));
  assign store_addr = tx_sop ? base : wr_ptr;
  assign wr_eop     = do_store & tx_eop;
  assign tx_drop    = wr_acc & ~tx_sop & tx_eop & (dropping | overflow);
  assign rd_word    = mem[rd_ptr[FIFO_AW-1:0]];
  assign rd_adv     = (state == DATA) & last_sub;
  assign rd_eop     = rd_adv & rd_word[9];
  assign unused_sop = rd_word[8];

  always_ff @(posedge tx_clk)
    if (do_store) mem[store_addr[FIFO_AW-1:0]] <= {tx_err, tx_eop, tx_sop, tx_data};

  always_ff @(posedge tx_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_start <= '0;
      pkt_cnt   <= '0;
      in_pkt    <= 1'b0;
      dropping  <= 1'b0;
      rdy_en    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (do_store) begin
        wr_ptr   <= store_addr + ONE;
        in_pkt   <= ~tx_eop;
        dropping <= 1'b0;
        if (tx_sop) pkt_start <= base;
      end else if (overflow) begin
        wr_ptr   <= pkt_start;
        in_pkt   <= 1'b0;
        dropping <= ~(wr_acc & tx_eop);
      end else if (wr_acc & tx_eop) begin
        dropping <= 1'b0;
      end
      if (rd_adv) rd_ptr <= rd_ptr + ONE;
      if (wr_eop & ~rd_eop)      pkt_cnt <= pkt_cnt + ONE;
      else if (rd_eop & ~wr_eop) pkt_cnt <= pkt_cnt - ONE;
    end
  end

  assign last_sub = (PHY_W == 8) | sub;
  assign fcs      = ~crc;
  assign err_now  = frame_err | rd_word[10];

  always_comb begin
    cur_byte = 8'h00;
    case (state)
      PREAMBLE: cur_byte = (cnt == 16'd7) ? 8'hD5 : 8'h55;
      DATA:     cur_byte = rd_word[7:0];
      CRC:      cur_byte = fcs[{cnt[1:0], 3'b000} +: 8];
      default:  cur_byte = 8'h00;
    endcase
    word = PHY_W'(cur_byte >> (sub ? 4 : 0));
  end

  always_ff @(posedge tx_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      sub         <= 1'b0;
      crc         <= '1;
      frame_err   <= 1'b0;
      eth_txen    <= 1'b0;
      eth_txer    <= 1'b0;
      eth_txd     <= '0;
      frames_sent <= '0;
    end else begin
      eth_txen <= 1'b0;
      eth_txer <= 1'b0;
      eth_txd  <= '0;
      case (state)
        IDLE: begin
          cnt       <= '0;
          sub       <= 1'b0;
          crc       <= '1;
          frame_err <= 1'b0;
          if (!pkt_none) state <= PREAMBLE;
        end
        PREAMBLE: begin
          eth_txen <= 1'b1;
          eth_txd  <= word;
          sub      <= ~last_sub;
          if (last_sub) begin
            if (cnt == 16'd7) begin
              cnt   <= '0;
              state <= DATA;
            end else cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          eth_txen  <= 1'b1;
          eth_txd   <= word;
          eth_txer  <= err_now;
          frame_err <= err_now;
          sub       <= ~last_sub;
          if (last_sub) begin
            crc <= crc_byte(crc, cur_byte);
            cnt <= cnt + 16'd1;
            if (rd_word[9]) begin
              if (cnt + 16'd1 >= MIN16) begin
                cnt   <= '0;
                state <= CRC;
              end else state <= PAD;
            end
          end
        end
        PAD: begin
          eth_txen <= 1'b1;
          eth_txd  <= word;
          eth_txer <= frame_err;
          sub      <= ~last_sub;
          if (last_sub) begin
            crc <= crc_byte(crc, cur_byte);
            if (cnt + 16'd1 >= MIN16) begin
              cnt   <= '0;
              state <= CRC;
            end else cnt <= cnt + 16'd1;
          end
        end
        CRC: begin
          eth_txen <= 1'b1;
          eth_txd  <= word;
          eth_txer <= frame_err;
          sub      <= ~last_sub;
          if (last_sub) begin
            if (cnt == 16'd3) begin
              cnt         <= '0;
              frames_sent <= frames_sent + 16'd1;
              state       <= IFG;
            end else cnt <= cnt + 16'd1;
          end
        end
        IFG: begin
          cnt <= cnt + 16'd1;
          if (cnt + 16'd1 >= IFG_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
